// File: rtl/pattern_scheduler.sv
// pattern_scheduler: selects the active test pattern and blanks the output for BLANK_FRAMES frames between patterns.
// Optional feature macro: PATTERN_SCHED_AUTO_EN enables the frame-counted auto-advance driven by dwell_sel/paused.
module pattern_scheduler #(
  parameter int NUM_PATTERNS = 6,
  parameter int BLANK_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       paused,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic [1:0] dwell_sel,
  output logic [2:0] pattern_id,
  output logic       blank,
  output logic       switch_pulse
);

  localparam logic [2:0] LAST_ID   = 3'(NUM_PATTERNS - 1);
  localparam logic [3:0] BLANK_END = 4'(BLANK_FRAMES - 1);

  typedef enum logic {ST_SHOW, ST_BLANK} state_t;

  state_t     state, state_n;
  logic [2:0] target, target_n, pattern_n;
  logic [3:0] blank_cnt, blank_cnt_n;
  logic       next_req, next_req_n, prev_req, prev_req_n;
  logic       switch_n;
  logic [2:0] next_sync, prev_sync;
  logic       next_edge, prev_edge, want_next, want_prev;
  logic [2:0] id_inc, id_dec;

  // Bit 0/1 form the two-flop synchronizer; bit 2 is the edge-detect history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      next_sync <= '0;
      prev_sync <= '0;
    end else begin
      next_sync <= {next_sync[1:0], btn_next};
      prev_sync <= {prev_sync[1:0], btn_prev};
    end
  end

  assign next_edge = next_sync[1] & ~next_sync[2];
  assign prev_edge = prev_sync[1] & ~prev_sync[2];
  assign want_next = next_req | next_edge;
  assign want_prev = prev_req | prev_edge;

  assign id_inc = (pattern_id == LAST_ID) ? 3'd0 : pattern_id + 3'd1;
  assign id_dec = (pattern_id == 3'd0) ? LAST_ID : pattern_id - 3'd1;

`ifdef PATTERN_SCHED_AUTO_EN
  logic [8:0] frame_cnt, frame_cnt_n, dwell_last;

  always_comb begin
    case (dwell_sel)
      2'd0:    dwell_last = 9'd59;
      2'd1:    dwell_last = 9'd119;
      2'd2:    dwell_last = 9'd239;
      default: dwell_last = 9'd479;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) frame_cnt <= '0;
    else        frame_cnt <= frame_cnt_n;
  end
`else
  logic unused_auto;
  assign unused_auto = ^{paused, dwell_sel};
`endif

  always_comb begin
    state_n     = state;
    target_n    = target;
    pattern_n   = pattern_id;
    blank_cnt_n = blank_cnt;
    next_req_n  = want_next;
    prev_req_n  = want_prev;
    switch_n    = 1'b0;
`ifdef PATTERN_SCHED_AUTO_EN
    frame_cnt_n = frame_cnt;
`endif
    case (state)
      ST_SHOW: begin
        if (frame_start) begin
          next_req_n = 1'b0;
          prev_req_n = 1'b0;
          if (want_next != want_prev) begin
            target_n = want_next ? id_inc : id_dec;
            state_n  = ST_BLANK;
`ifdef PATTERN_SCHED_AUTO_EN
            frame_cnt_n = '0;
`endif
          end
`ifdef PATTERN_SCHED_AUTO_EN
          // Requests equal here, so !want_next means nothing pending; both pending makes the frame inert.
          else if (!want_next && !paused) begin
            if (frame_cnt >= dwell_last) begin
              target_n    = id_inc;
              state_n     = ST_BLANK;
              frame_cnt_n = '0;
            end else begin
              frame_cnt_n = frame_cnt + 9'd1;
            end
          end
`endif
        end
      end
      ST_BLANK: begin
        next_req_n = 1'b0;
        prev_req_n = 1'b0;
        if (frame_start) begin
          if (blank_cnt == BLANK_END) begin
            pattern_n   = target;
            switch_n    = 1'b1;
            blank_cnt_n = '0;
            state_n     = ST_SHOW;
          end else begin
            blank_cnt_n = blank_cnt + 4'd1;
          end
        end
      end
      default: state_n = ST_SHOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_SHOW;
      target       <= '0;
      pattern_id   <= '0;
      blank_cnt    <= '0;
      next_req     <= 1'b0;
      prev_req     <= 1'b0;
      blank        <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      state        <= state_n;
      target       <= target_n;
      pattern_id   <= pattern_n;
      blank_cnt    <= blank_cnt_n;
      next_req     <= next_req_n;
      prev_req     <= prev_req_n;
      blank        <= (state_n == ST_BLANK);
      switch_pulse <= switch_n;
    end
  end

endmodule

// File: tb/tb_pattern_scheduler.sv
// tb_pattern_scheduler: directed and randomized checks of pattern_scheduler against a frame-level behavioural model.
// Auto-advance scenarios are compiled only when PATTERN_SCHED_AUTO_EN is defined, matching the DUT build.
module tb_pattern_scheduler;

  localparam int NP = 6;
  localparam int BF = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       paused = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_prev = 1'b0;
  logic [1:0] dwell_sel = 2'd0;
  logic [2:0] pattern_id;
  logic       blank;
  logic       switch_pulse;

  int total = 0;
  int bad = 0;

  pattern_scheduler #(.NUM_PATTERNS(NP), .BLANK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .paused(paused),
    .btn_next(btn_next), .btn_prev(btn_prev), .dwell_sel(dwell_sel),
    .pattern_id(pattern_id), .blank(blank), .switch_pulse(switch_pulse)
  );

  always #5 clk = ~clk;

  bit         m_valid = 0;
  bit         m_showing = 1;
  bit         m_switch = 0;
  bit         m_nreq = 0, m_preq = 0;
  int         m_pid = 0, m_target = 0, m_frames = 0, m_blank_seen = 0;
  logic [2:0] hist_next = '0, hist_prev = '0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_blank(input int tgt);
    m_target     = tgt;
    m_showing    = 0;
    m_frames     = 0;
    m_blank_seen = 0;
  endtask

  // A press is seen by the scheduler two clocks after it is sampled, as a 0->1 step.
  task automatic model_step();
    bit en, ep, rn, rp;
    if (!rst_n) begin
      m_valid = 1; m_showing = 1; m_switch = 0; m_nreq = 0; m_preq = 0;
      m_pid = 0; m_target = 0; m_frames = 0; m_blank_seen = 0;
      hist_next = '0; hist_prev = '0;
      return;
    end
    en = hist_next[1] & ~hist_next[2];
    ep = hist_prev[1] & ~hist_prev[2];
    hist_next = {hist_next[1:0], btn_next};
    hist_prev = {hist_prev[1:0], btn_prev};
    m_switch = 0;
    if (m_showing) begin
      rn = m_nreq | en;
      rp = m_preq | ep;
      if (!frame_start) begin
        m_nreq = rn;
        m_preq = rp;
      end else begin
        m_nreq = 0;
        m_preq = 0;
        if (rn != rp) start_blank(rn ? (m_pid + 1) % NP : (m_pid + NP - 1) % NP);
`ifdef PATTERN_SCHED_AUTO_EN
        else if (!rn && !paused) begin
          m_frames++;
          if (m_frames >= (60 << dwell_sel)) start_blank((m_pid + 1) % NP);
        end
`endif
      end
    end else begin
      m_nreq = 0;
      m_preq = 0;
      if (frame_start) begin
        m_blank_seen++;
        if (m_blank_seen == BF) begin
          m_pid     = m_target;
          m_switch  = 1;
          m_showing = 1;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    if (m_valid) begin
      check_output("cyc_pattern_id", pattern_id, m_pid);
      check_output("cyc_blank", blank, !m_showing);
      check_output("cyc_switch_pulse", switch_pulse, m_switch);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic apply_frame();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
  endtask

  task automatic apply_stimulus(input logic n, input logic p, input int len);
    @(negedge clk);
    btn_next = n;
    btn_prev = p;
    idle(len);
    btn_next = 1'b0;
    btn_prev = 1'b0;
  endtask

  int btn_rate;

  initial begin
    $display("[TB] start");
    do_reset();
    check_output("rst_pattern_id", pattern_id, 0);
    check_output("rst_blank", blank, 0);
    check_output("rst_switch", switch_pulse, 0);

    // Previous from pattern 0 wraps to the last pattern; a press during blanking is dropped.
    apply_stimulus(1'b0, 1'b1, 3);
    idle(5);
    apply_frame();
    check_output("prev_blank_rise", blank, 1);
    apply_stimulus(1'b1, 1'b0, 3);
    idle(5);
    repeat (3) begin idle(3); apply_frame(); end
    check_output("prev_still_blank", blank, 1);
    check_output("prev_id_held", pattern_id, 0);
    idle(3);
    apply_frame();
    check_output("prev_wrap_id", pattern_id, 5);
    check_output("prev_switch", switch_pulse, 1);
    check_output("prev_blank_fall", blank, 0);
    check_output("model_prev_wrap", m_pid, 5);
    idle(1);
    check_output("switch_one_cycle", switch_pulse, 0);
    idle(3);
    apply_frame();
    check_output("blank_press_discarded", blank, 0);

    // Both buttons in one frame cancel each other.
    apply_stimulus(1'b1, 1'b1, 3);
    idle(5);
    apply_frame();
    check_output("both_no_blank", blank, 0);
    check_output("both_id_kept", pattern_id, 5);
    idle(3);
    apply_frame();
    check_output("both_flags_cleared", blank, 0);

`ifdef PATTERN_SCHED_AUTO_EN
    do_reset();
    dwell_sel = 2'd0;
    repeat (59) begin idle(2); apply_frame(); end
    check_output("auto_before_dwell", blank, 0);
    idle(2); apply_frame();
    check_output("auto_blank_rise", blank, 1);
    repeat (4) begin idle(2); apply_frame(); end
    check_output("auto_id", pattern_id, 1);
    check_output("auto_switch", switch_pulse, 1);

    paused = 1'b1;
    repeat (100) begin idle(2); apply_frame(); end
    check_output("paused_no_auto", blank, 0);
    apply_stimulus(1'b1, 1'b0, 3);
    idle(5);
    apply_frame();
    check_output("paused_manual_blank", blank, 1);
    repeat (4) begin idle(2); apply_frame(); end
    check_output("paused_manual_id", pattern_id, 2);
    paused = 1'b0;

    dwell_sel = 2'd1;
    repeat (100) begin idle(2); apply_frame(); end
    check_output("dwell120_no_auto", blank, 0);
    dwell_sel = 2'd0;
    idle(2); apply_frame();
    check_output("dwell_drop_blank", blank, 1);
    repeat (4) begin idle(2); apply_frame(); end
    check_output("dwell_drop_id", pattern_id, 3);
`endif

    // Reset in the second blank frame abandons the pending switch.
    do_reset();
    apply_stimulus(1'b1, 1'b0, 3);
    idle(5);
    apply_frame();
    idle(3);
    apply_frame();
    check_output("midblank_blank", blank, 1);
    idle(1);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    check_output("midblank_rst_blank", blank, 0);
    check_output("midblank_rst_id", pattern_id, 0);
    repeat (5) begin idle(3); apply_frame(); end
    check_output("midblank_no_switch_id", pattern_id, 0);
    check_output("midblank_no_blank", blank, 0);

    do_reset();
    for (int i = 0; i < 25000; i++) begin
      btn_rate = (i < 10000) ? 30 : 400;
      @(negedge clk);
      frame_start = !frame_start && ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, btn_rate - 1) == 0) btn_next = ~btn_next;
      if ($urandom_range(0, btn_rate - 1) == 0) btn_prev = ~btn_prev;
      if ($urandom_range(0, 99) == 0) paused = ~paused;
      if ($urandom_range(0, 499) == 0) dwell_sel = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 4999) != 0);
    end
    rst_n = 1'b1;
    frame_start = 1'b0;
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
